// File: rtl/conv_row_sequencer_if.sv
// conv_row_sequencer_if
//   Bundles the sequencer's control/handshake signals.
//   master : the sequencer (drives commands, stage code, accumulator gates,
//            output-row valid, status pulses; receives start/ack/ready)
//   slave  : the surrounding datapath / testbench
interface conv_row_sequencer_if #(
  parameter int ROW_W = 3
);
  logic             start;
  logic [1:0]       if_cmd;
  logic [ROW_W-1:0] if_row;
  logic [1:0]       if_ack;
  logic [2:0]       stage;
  logic [3:0]       weight_addr;
  logic             acc_clear;
  logic             acc_en;
  logic             out_valid;
  logic [ROW_W-1:0] out_row;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, if_ack, out_ready,
    output if_cmd, if_row, stage, weight_addr, acc_clear, acc_en,
           out_valid, out_row, busy, done, err
  );

  modport slave (
    output start, if_ack, out_ready,
    input  if_cmd, if_row, stage, weight_addr, acc_clear, acc_en,
           out_valid, out_row, busy, done, err
  );
endinterface

// File: rtl/conv_row_sequencer.sv
// conv_row_sequencer
//   Moore sequencer for one convolution image pass. For each output row r it
//   clears the accumulators, then for each kernel row k loads image row r+k
//   through the cmd/ack input interface and steps the KERNEL_SIZE kernel
//   columns with accumulation enabled, then offers row r downstream with a
//   valid/ready handshake.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous reset, ACTIVE HIGH despite the name
//   bus    : conv_row_sequencer_if.master (start, if_cmd/if_row/if_ack,
//            stage, weight_addr, acc_clear, acc_en, out_valid/out_row/
//            out_ready, busy, done, err)
// KERNEL_SIZE must be 2 or 3: stage codes 2..4 cover at most three kernel rows.
module conv_row_sequencer #(
  parameter int IMAGE_SIZE  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv_row_sequencer_if.master  bus
);

  // Encodings equal the published stage codes; STAGE_ROW_k shares one
  // state and adds k when the code is emitted.
  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_PREP = 3'd1,
    S_ROW  = 3'd2,
    S_WB   = 3'd5,
    S_IDLE = 3'd7
  } state_e;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_SIZE - KERNEL_SIZE);
  localparam logic [1:0]       LAST_K   = 2'(KERNEL_SIZE - 1);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] r_q, r_d;
  logic [1:0]       k_q, k_d;
  logic [1:0]       c_q, c_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      k_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      c_q     <= c_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state and counters. Counters only move on the listed transitions,
  // so stalls in PREP (no ack) and WB (no ready) leave them untouched.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    c_d     = c_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          r_d     = '0;
          k_d     = '0;
          c_d     = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: state_d = S_PREP;
      S_PREP: begin
        // 2'b10 is reserved and falls through as "no response"
        if (bus.if_ack == 2'b01) begin
          c_d     = '0;
          state_d = S_ROW;
        end else if (bus.if_ack == 2'b11) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ROW: begin
        if (c_q == LAST_K) begin
          c_d = '0;
          if (k_q != LAST_K) begin
            k_d     = k_q + 2'd1;
            state_d = S_PREP;
          end else begin
            state_d = S_WB;
          end
        end else begin
          c_d = c_q + 2'd1;
        end
      end
      S_WB: begin
        if (bus.out_ready) begin
          if (r_q == LAST_ROW) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            r_d     = r_q + ROW_W'(1);
            k_d     = '0;
            state_d = S_INIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: pure decode of registered state/counters.
  always_comb begin
    bus.stage       = state_q;
    bus.if_cmd      = 2'b00;
    bus.if_row      = '0;
    bus.weight_addr = '0;
    bus.acc_clear   = 1'b0;
    bus.acc_en      = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_row     = '0;
    bus.busy        = (state_q != S_IDLE);
    bus.done        = done_q;
    bus.err         = err_q;
    case (state_q)
      S_INIT: bus.acc_clear = 1'b1;
      S_PREP: begin
        bus.if_cmd = 2'b01;
        bus.if_row = r_q + ROW_W'(k_q);
      end
      S_ROW: begin
        bus.stage       = 3'd2 + 3'(k_q);
        bus.acc_en      = 1'b1;
        bus.weight_addr = 4'(k_q) * 4'(KERNEL_SIZE) + 4'(c_q);
      end
      S_WB: begin
        bus.out_valid = 1'b1;
        bus.out_row   = r_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/conv_row_sequencer.md
# conv_row_sequencer

Moore-style sequencer for the convolution layer. It drives the input interface with the `cmd`/`ack` handshake, publishes the 3-bit stage code used by the weight cache, and gates the kernel array's accumulators. It walks every output row of the image: for each kernel row it loads one image row, then steps the kernel columns. It hands each finished row to the output side with a valid/ready handshake.

## Interface
- `IMAGE_SIZE`, 8: input image width/height in pixels.
- `KERNEL_SIZE`, 3: kernel is KERNEL_SIZE x KERNEL_SIZE. Must satisfy 1 < KERNEL_SIZE <= 3 because stage codes are fixed.
- `ROW_W`, 3: width of row indices. Must be >= clog2(IMAGE_SIZE).
- `clk` in 1: the single clock. Everything is on its rising edge.
- `rst_n` in 1: reset. **Asynchronous and active-high**: the block is in reset while `rst_n`=1, despite the codebase port name.
- `start` in 1: one-cycle request to process a full image. Honoured only in IDLE.
- `if_cmd` out 2: command to the input interface. 00 NOP, 01 LOAD_ROW.
- `if_row` out ROW_W: image row to load. Valid while `if_cmd`=01.
- `if_ack` in 2: input interface response. 00 none, 01 load done, 11 error. 10 is reserved and treated as none.
- `stage` out 3: stage code. INIT=0, PREPARE_LOAD=1, STAGE_ROW_0..2=2..4, WRITEBACK=5, IDLE=7.
- `weight_addr` out 4: kernel weight index, k*KERNEL_SIZE+c.
- `acc_clear` out 1: clear the kernel-array accumulators.
- `acc_en` out 1: accumulate this cycle's pixel x weight.
- `out_valid` out 1: a finished output row is ready.
- `out_row` out ROW_W: index of the finished output row.
- `out_ready` in 1: downstream accepts the row.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse when the image is complete.
- `err` out 1: one-cycle pulse on an aborted image.

## Operation
- Registers:
  - state
  - output-row counter `r`, range 0..IMAGE_SIZE-KERNEL_SIZE
  - kernel-row counter `k`, range 0..KERNEL_SIZE-1
  - column counter `c`, range 0..KERNEL_SIZE-1
  - `done_q`, `err_q`
- All outputs except `done`/`err` decode combinationally from the registered state and counters.
- **IDLE**
  - `start`=1: clear r, k, c; go to INIT.
  - Otherwise stay.
- **INIT** (1 cycle): `acc_clear`=1; go to PREPARE_LOAD.
- **PREPARE_LOAD**
  - Drives `if_cmd`=01 and `if_row`=r+k.
  - `if_ack`=01: c=0; go to STAGE_ROW_k.
  - `if_ack`=11: go to IDLE with an `err` pulse.
  - Otherwise hold.
- **STAGE_ROW_k**
  - `acc_en`=1, `weight_addr`=k*KERNEL_SIZE+c, `if_cmd`=00.
  - Each cycle c increments.
  - At c=KERNEL_SIZE-1:
    - if k<KERNEL_SIZE-1: k++, go to PREPARE_LOAD;
    - else go to WRITEBACK.
- **WRITEBACK**
  - `out_valid`=1, `out_row`=r.
  - Handshake on `out_ready`=1:
    - if r=IMAGE_SIZE-KERNEL_SIZE: go to IDLE with a `done` pulse;
    - else r++, k=0, go to INIT.
- Outside their states: `acc_en`, `acc_clear` and `out_valid` are 0; `if_cmd`=00; `if_row` and `weight_addr` are 0.
- Rows are processed in ascending order. Each output row reloads all KERNEL_SIZE image rows; there is no row reuse in this version.
- `start` outside IDLE is ignored, including in the same cycle as the `done` transition.
- `if_ack` outside PREPARE_LOAD is ignored. `out_ready` outside WRITEBACK is ignored.

## Timing
- **Reset values:**
  - state=IDLE, so `stage`=7;
  - r=k=c=0;
  - all outputs 0 except `stage`.
- Reset assertion mid-image forces IDLE immediately (asynchronous), with no `done` and no `err`.
- `start` sampled at edge T gives `stage`=0 and `acc_clear`=1 in cycle T+1.
- `if_ack`=01 may arrive in the first cycle `if_cmd`=01 is shown. The next cycle is then STAGE_ROW.
- Minimum cycles per output row with zero-wait `ack` and `ready`: 1 + KERNEL_SIZE*(1+KERNEL_SIZE) + 1 = 14 for the defaults.
- Full 8x8 image from `start` to `done` = 6*14 + 1 = 85 cycles minimum.
- `done` and `err` are registered. They are high for exactly the first IDLE cycle after the completing or aborting transition.
- Back-pressure: `out_valid` and `out_row` stay stable until `out_ready`. Arbitrary stalls in PREPARE_LOAD and WRITEBACK do not change counters.

## Test plan
- Reset then `start` with immediate `ack`/`ready`:
  - `if_row` sequence is 0,1,2,1,2,3,…,5,6,7;
  - `weight_addr` cycles 0..8 per output row;
  - `out_row` goes 0..5;
  - `done` is high at cycle 85 and for one cycle only.
- `if_ack` delayed 4 cycles per load:
  - `if_cmd`/`if_row` are held stable;
  - `stage` stays 1;
  - total latency is 85 + 18*4 = 157 cycles.
- `out_ready` low for 5 cycles on row 2: `out_valid`=1 and `out_row`=2 are held; no `acc_en` or `acc_clear` occurs during the stall.
- `if_ack`=11 on the third load of row 3: `err` pulses once, the block returns to IDLE with `stage`=7, and there is no `done`. A following `start` restarts at `if_row`=0.
- `start` pulsed mid-image and in the `done` cycle: no effect, and the sequence is identical to the first test.
- `rst_n` asserted during STAGE_ROW_1: all outputs 0 and `stage`=7 in the same cycle. After release, `start` yields the normal 85-cycle run.
